inv_key_expan: RTL and testbench

INV_KEY_EXPAN -- requirements
Module: inv_key_expan

---
 rtl/inv_key_expan_pkg.sv | 53 +++++
 rtl/inv_key_expan_bytesub.sv | 16 +
 rtl/inv_key_expan.sv | 91 +++++++++
 tb/tb_inv_key_expan.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_key_expan_pkg.sv
// Shared AES definitions: round count, FSM encoding, Rcon table and S-box lookup.
package inv_key_expan_pkg;

  localparam int unsigned NUM_ROUNDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Entry 0x00 sits in the top byte; each line holds 16 consecutive entries.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8 * (255 - int'(x)) +: 8];
  endfunction

endpackage

// File: rtl/inv_key_expan_bytesub.sv
// 32-bit word S-box substitution (SubWord), purely combinational.
module byteSub
  import inv_key_expan_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  always_comb begin
    out_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_word[8*i +: 8] = sbox(in_word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/inv_key_expan.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to the cipher key,
// presenting one round key per accepted valid/ready beat.
module inv_key_expan
  import inv_key_expan_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = inv_key_expan_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  state_t       state_q, state_d;
  logic [127:0] key_d;
  logic [3:0]   idx_d;
  logic         done_d;

  logic [31:0] a0, a1, a2, a3;
  logic [31:0] b0, b1, b2, b3;
  logic [31:0] sub_in, sub_out;

  assign a0 = round_key[127:96];
  assign a1 = round_key[95:64];
  assign a2 = round_key[63:32];
  assign a3 = round_key[31:0];

  // Undo the forward recurrence from the top word down; b3 feeds the g-function for b0.
  assign b3     = a3 ^ a2;
  assign b2     = a2 ^ a1;
  assign b1     = a1 ^ a0;
  assign sub_in = {b3[23:0], b3[31:24]};
  assign b0     = a0 ^ sub_out ^ {rcon(round_idx), 24'h0};

  byteSub u_byte_sub (
    .in_word  (sub_in),
    .out_word (sub_out)
  );

  always_comb begin
    state_d = state_q;
    key_d   = round_key;
    idx_d   = round_idx;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          idx_d   = 4'(NUM_ROUNDS);
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (round_idx == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = {b0, b1, b2, b3};
            idx_d = round_idx - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_key <= key_d;
      round_idx <= idx_d;
      done      <= done_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_inv_key_expan.sv
// Scoreboard bench for inv_key_expan using the FIPS-197 A.1 key schedule.
module tb_inv_key_expan;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] last_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  inv_key_expan #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .last_key  (last_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] a1_keys [0:10];
  logic         exp_done;
  int           checks = 0;
  int           fails  = 0;

  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    a1_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  end

  // Monitor: compare the presented key against the queue head every valid cycle,
  // pop on handshake, and expect done exactly one cycle after the idx-0 pop.
  always @(negedge clk) begin
    logic nxt_done;
    exp_t e;
    if (reset_n) begin
      nxt_done = 1'b0;
      checks++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL done_pulse: got %b want %b at %0t", done, exp_done, $time);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got idx=%0d key=%h with empty scoreboard", round_idx, round_key);
        end else begin
          e = sb[0];
          if (round_idx !== e.idx || round_key !== e.key) begin
            fails++;
            $display("FAIL beat: got idx=%0d key=%h want idx=%0d key=%h", round_idx, round_key, e.idx, e.key);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            if (e.idx == 4'd0) nxt_done = 1'b1;
          end
        end
      end
      exp_done = nxt_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_a1();
    for (int r = 10; r >= 0; r--) sb.push_back('{idx: 4'(r), key: a1_keys[r]});
  endtask

  task automatic start_seq(input logic [127:0] key);
    start    = 1'b1;
    last_key = key;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    check({name, "_done_seen"}, 128'(done), 128'd1);
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n = 0;
    while (!(out_valid && round_idx == idx) && n < 20) begin
      tick();
      n++;
    end
    check("wait_idx", 128'(round_idx), 128'(idx));
  endtask

  initial begin
    int cyc;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    last_key  = '0;
    exp_done  = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_done",      128'(done),      128'd0);
    check("rst_round_key", round_key,       128'd0);
    check("rst_round_idx", 128'(round_idx), 128'd0);
    reset_n = 1'b1;
    tick();

    // FIPS-197 A.1, full throughput
    out_ready = 1'b1;
    push_a1();
    start_seq(a1_keys[10]);
    check("a1_busy", 128'(busy), 128'd1);
    wait_done("a1", cyc);
    check("a1_cycles",     128'(cyc),       128'd11);
    check("a1_sb_empty",   128'(sb.size()), 128'd0);
    check("a1_idle_valid", 128'(out_valid), 128'd0);
    check("a1_idle_busy",  128'(busy),      128'd0);
    tick();
    check("a1_done_once",  128'(done),      128'd0);
    check("a1_idle_key",   round_key,       a1_keys[0]);
    check("a1_idle_idx",   128'(round_idx), 128'd0);

    // Backpressure at idx 9
    push_a1();
    start_seq(a1_keys[10]);
    tick();
    check("bp_idx9", 128'(round_idx), 128'd9);
    out_ready = 1'b0;
    repeat (3) tick();
    check("bp_hold_idx", 128'(round_idx), 128'd9);
    check("bp_hold_key", round_key,       a1_keys[9]);
    out_ready = 1'b1;
    wait_done("bp", cyc);
    check("bp_sb_empty", 128'(sb.size()), 128'd0);
    tick();

    // Start held during RUN, including the final handshake cycle
    push_a1();
    start_seq(a1_keys[10]);
    start    = 1'b1;
    last_key = K2;
    wait_done("swb", cyc);
    start = 1'b0;
    check("swb_cycles", 128'(cyc), 128'd11);
    repeat (3) tick();
    check("swb_idle_busy", 128'(busy),      128'd0);
    check("swb_idle_key",  round_key,       a1_keys[0]);
    check("swb_sb_empty",  128'(sb.size()), 128'd0);

    // Reset at idx 5, then a fresh start
    push_a1();
    start_seq(a1_keys[10]);
    wait_idx(4'd5);
    out_ready = 1'b0;
    reset_n   = 1'b0;
    tick();
    check("mr_valid", 128'(out_valid), 128'd0);
    check("mr_busy",  128'(busy),      128'd0);
    sb.delete();
    exp_done = 1'b0;
    reset_n  = 1'b1;
    tick();
    check("mr_no_beat", 128'(out_valid), 128'd0);
    sb.push_back('{idx: 4'd10, key: K2});
    start_seq(K2);
    tick();
    tick();
    check("mr_new_key", round_key,       K2);
    check("mr_new_idx", 128'(round_idx), 128'd10);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    exp_done = 1'b0;
    tick();
    check("mr_no_done", 128'(done), 128'd0);
    tick();

    // Back-to-back: start in the done cycle
    out_ready = 1'b1;
    push_a1();
    start_seq(a1_keys[10]);
    wait_done("b2b_first", cyc);
    push_a1();
    start_seq(a1_keys[10]);
    check("b2b_valid", 128'(out_valid), 128'd1);
    check("b2b_idx",   128'(round_idx), 128'd10);
    wait_done("b2b_second", cyc);
    check("b2b_sb_empty", 128'(sb.size()), 128'd0);
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "timeout");
  end

endmodule
